mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory port of the arbiter.
// The master side is the environment (requesters plus memory); the slave is the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 8
);
  logic                req0;
  logic                req1;
  logic                we0;
  logic                we1;
  logic [ADDR_LEN-1:0] addr0;
  logic [ADDR_LEN-1:0] addr1;
  logic [WORD_LEN-1:0] wdata0;
  logic [WORD_LEN-1:0] wdata1;
  logic                ack0;
  logic                ack1;
  logic [WORD_LEN-1:0] rdata0;
  logic [WORD_LEN-1:0] rdata1;
  logic                busy;
  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_r_en;
  logic                mem_w_en;
  logic [WORD_LEN-1:0] mem_data_in;
  logic [WORD_LEN-1:0] mem_data_out;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, rdata0, rdata1, busy, mem_addr, mem_r_en, mem_w_en, mem_data_in
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, rdata0, rdata1, busy, mem_addr, mem_r_en, mem_w_en, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory with
// combinational read data. Each access takes IDLE -> ACCESS -> RESP, so one
// access completes every three cycles at best; all outputs are registered.
module mem_arbiter #(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last_gnt;
  logic                r_gnt;
  logic                r_we;
  logic [ADDR_LEN-1:0] r_addr;
  logic [WORD_LEN-1:0] r_wdata;
  logic                r_ack0;
  logic                r_ack1;
  logic [WORD_LEN-1:0] r_rdata0;
  logic [WORD_LEN-1:0] r_rdata1;
  logic                r_mem_r_en;
  logic                r_mem_w_en;
  logic                r_busy;

  logic                w_any_req;
  logic                w_gnt;
  logic                w_gnt_we;
  logic [ADDR_LEN-1:0] w_gnt_addr;
  logic [WORD_LEN-1:0] w_gnt_wdata;

  // On a tie the port that did not win last time gets the grant.
  assign w_any_req   = bus.req0 | bus.req1;
  assign w_gnt       = (bus.req0 & bus.req1) ? ~r_last_gnt : bus.req1;
  assign w_gnt_we    = w_gnt ? bus.we1    : bus.we0;
  assign w_gnt_addr  = w_gnt ? bus.addr1  : bus.addr0;
  assign w_gnt_wdata = w_gnt ? bus.wdata1 : bus.wdata0;

  // Arbitration FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_gnt      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state    <= ACCESS;
            r_gnt      <= w_gnt;
            r_last_gnt <= w_gnt;
            r_we       <= w_gnt_we;
            r_addr     <= w_gnt_addr;
            r_wdata    <= w_gnt_wdata;
            r_mem_r_en <= ~w_gnt_we;
            r_mem_w_en <= w_gnt_we;
            r_busy     <= 1'b1;
          end
        end
        ACCESS: begin
          r_state    <= RESP;
          r_mem_r_en <= 1'b0;
          r_mem_w_en <= 1'b0;
          if (!r_we) begin
            if (r_gnt) r_rdata1 <= bus.mem_data_out;
            else       r_rdata0 <= bus.mem_data_out;
          end
          r_ack0 <= ~r_gnt;
          r_ack1 <= r_gnt;
        end
        RESP: begin
          r_state <= IDLE;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_ack0     <= 1'b0;
          r_ack1     <= 1'b0;
          r_mem_r_en <= 1'b0;
          r_mem_w_en <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Address and write data stay on the memory bus until the next grant.
  assign bus.mem_addr    = r_addr;
  assign bus.mem_data_in = r_wdata;
  assign bus.mem_r_en    = r_mem_r_en;
  assign bus.mem_w_en    = r_mem_w_en;
  assign bus.ack0        = r_ack0;
  assign bus.ack1        = r_ack1;
  assign bus.rdata0      = r_rdata0;
  assign bus.rdata1      = r_rdata1;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queued requester transactions on both ports, a
// behavioural memory, and a transaction-timeline reference model.
module tb_mem_arbiter;
  localparam int AL = 8;
  localparam int WL = 8;

  typedef struct {
    logic          we;
    logic [AL-1:0] addr;
    logic [WL-1:0] data;
    int            gap;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_init;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_LEN(AL), .WORD_LEN(WL)) bus ();

  mem_arbiter #(.ADDR_LEN(AL), .WORD_LEN(WL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural memory: combinational read, write on the rising edge.
  logic [WL-1:0] mem [256];
  assign bus.mem_data_out = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (bus.mem_w_en) begin
      mem[bus.mem_addr] <= bus.mem_data_in;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: one grant at cycle g means enables in g+1, ack in g+2,
  // next grant possible at g+3.
  int            m_g;
  int            m_free_at;
  int            m_port;
  int            m_last;
  logic          m_we;
  logic [AL-1:0] m_addr;
  logic [WL-1:0] m_wdata;
  logic [WL-1:0] exp_rd [2];
  logic [AL-1:0] exp_maddr;
  logic [WL-1:0] exp_mdin;
  logic [WL-1:0] ref_mem [256];

  txn_t q0[$];
  txn_t q1[$];
  bit   pres [2];
  bit   rst_req;
  int   rst_hold;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_g       = -1;
    m_free_at = cyc + 1;
    m_last    = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_maddr = '0;
    exp_mdin  = '0;
  endtask

  // Present the head of a port's queue; drop req in the ack cycle and for
  // 'gap' further cycles before the next transaction.
  task automatic drive_port(input int p, input bit acked);
    txn_t t;
    bit   have;
    have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (acked) begin
      if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      pres[p] = 1'b0;
    end else if (!pres[p] && have) begin
      if (p == 0) begin
        if (q0[0].gap > 0) q0[0].gap = q0[0].gap - 1; else pres[p] = 1'b1;
      end else begin
        if (q1[0].gap > 0) q1[0].gap = q1[0].gap - 1; else pres[p] = 1'b1;
      end
    end
    if (pres[p]) begin
      t = (p == 0) ? q0[0] : q1[0];
    end else begin
      t.we = 1'($urandom); t.addr = 8'($urandom); t.data = 8'($urandom); t.gap = 0;
    end
    if (p == 0) begin
      bus.req0 = pres[0]; bus.we0 = t.we; bus.addr0 = t.addr; bus.wdata0 = t.data;
    end else begin
      bus.req1 = pres[1]; bus.we1 = t.we; bus.addr1 = t.addr; bus.wdata1 = t.data;
    end
  endtask

  task automatic cycle_step();
    bit acc;
    bit rsp;
    @(negedge clk);
    mem_init = 1'b0;
    acc = (m_g >= 0) && (cyc == m_g + 1);
    rsp = (m_g >= 0) && (cyc == m_g + 2);
    if (rsp && !m_we) exp_rd[m_port] = ref_mem[m_addr];
    check_val("busy",     32'(bus.busy),     32'(acc || rsp));
    check_val("mem_r_en", 32'(bus.mem_r_en), 32'(acc && !m_we));
    check_val("mem_w_en", 32'(bus.mem_w_en), 32'(acc && m_we));
    check_val("ack0",     32'(bus.ack0),     32'(rsp && m_port == 0));
    check_val("ack1",     32'(bus.ack1),     32'(rsp && m_port == 1));
    check_val("ack_both", 32'(bus.ack0 & bus.ack1), 32'(0));
    check_val("mem_addr", 32'(bus.mem_addr), 32'(exp_maddr));
    check_val("mem_din",  32'(bus.mem_data_in), 32'(exp_mdin));
    check_val("rdata0",   32'(bus.rdata0),   32'(exp_rd[0]));
    check_val("rdata1",   32'(bus.rdata1),   32'(exp_rd[1]));
    if (rsp)
      $display("txn cyc=%0d port=%0d %s addr=%02h data=%02h", cyc, m_port,
               m_we ? "WR" : "RD", m_addr, m_we ? m_wdata : exp_rd[m_port]);
    if (acc && m_we) ref_mem[m_addr] = m_wdata;
    drive_port(0, rsp && m_port == 0);
    drive_port(1, rsp && m_port == 1);
    rst_n = 1'b1;
    if (rst_hold > 0) begin
      rst_n = 1'b0;
      rst_hold--;
    end
    if (rst_req && acc) begin
      rst_n   = 1'b0;
      rst_req = 1'b0;
      $display("txn cyc=%0d reset asserted during access of port %0d", cyc, m_port);
    end
    if (!rst_n) begin
      model_reset();
    end else if (cyc >= m_free_at && (bus.req0 || bus.req1)) begin
      m_port    = (bus.req0 && bus.req1) ? ((m_last == 1) ? 0 : 1) : (bus.req1 ? 1 : 0);
      m_last    = m_port;
      m_g       = cyc;
      m_free_at = cyc + 3;
      m_we      = (m_port == 1) ? bus.we1    : bus.we0;
      m_addr    = (m_port == 1) ? bus.addr1  : bus.addr0;
      m_wdata   = (m_port == 1) ? bus.wdata1 : bus.wdata0;
      exp_maddr = m_addr;
      exp_mdin  = m_wdata;
    end
    cyc++;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && cyc >= m_free_at && rst_hold == 0) && n < budget) begin
      cycle_step();
      n++;
    end
    check_val("drain_timeout", 32'(n >= budget), 32'(0));
    cycle_step();
  endtask

  function automatic txn_t mk(input logic we, input logic [AL-1:0] a, input logic [WL-1:0] d, input int gap);
    txn_t t;
    t.we = we; t.addr = a; t.data = d; t.gap = gap;
    return t;
  endfunction

  initial begin
    rst_n    = 1'b0;
    mem_init = 1'b1;
    rst_hold = 2;
    rst_req  = 1'b0;
    pres[0]  = 1'b0;
    pres[1]  = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    model_reset();
    m_free_at = 0;

    // Simultaneous first requests after reset: port 0 wins the tie.
    q0.push_back(mk(1'b0, 8'h20, 8'h00, 0));
    q1.push_back(mk(1'b0, 8'h21, 8'h00, 0));
    run_until_idle(100);

    // Port 0 write 0xA5 to 0x10, then read it back.
    q0.push_back(mk(1'b1, 8'h10, 8'hA5, 0));
    q0.push_back(mk(1'b0, 8'h10, 8'h00, 0));
    run_until_idle(100);

    // rdata0 = 0x11, then a port 1 read must leave rdata0 alone.
    q0.push_back(mk(1'b1, 8'h40, 8'h11, 0));
    q0.push_back(mk(1'b0, 8'h40, 8'h00, 1));
    run_until_idle(100);
    q1.push_back(mk(1'b0, 8'h3C, 8'h00, 0));
    run_until_idle(100);

    // Address extremes.
    q1.push_back(mk(1'b0, 8'hFF, 8'h00, 0));
    q1.push_back(mk(1'b1, 8'h00, 8'h77, 0));
    q1.push_back(mk(1'b0, 8'h00, 8'h00, 0));
    run_until_idle(100);

    // Both ports continuously busy, one idle cycle after each own ack.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 8'(8'h80 + i), 8'h00, (i == 0) ? 0 : 1));
      q1.push_back(mk(1'b1, 8'(8'h90 + i), 8'(8'hC0 + i), (i == 0) ? 0 : 1));
    end
    run_until_idle(200);

    // Reset during ACCESS aborts the access; the request is then re-served.
    rst_req = 1'b1;
    q1.push_back(mk(1'b0, 8'h90, 8'h00, 0));
    run_until_idle(100);
    check_val("rst_consumed", 32'(rst_req), 32'(0));

    // Randomised traffic on both ports.
    for (int i = 0; i < 30; i++) begin
      q0.push_back(mk(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2))));
      q1.push_back(mk(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2))));
    end
    run_until_idle(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
